// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single line-wide Data_Memory port between two line-fill
// requesters (port 0 = dcache, port 1 = instruction-side cache). One
// requester is granted at a time; its command is registered onto the
// memory port and held until the memory acknowledges, then ack/read data
// are routed back to the owner.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//   defined     -> ties go to the port that was not granted last
//   not defined -> fixed priority, port 0 always wins ties
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              owner_o,
  output logic              busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              mem_enable_d;
  logic              mem_write_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_data_d;
  logic              owner_d;
  logic              busy_d;
  logic              any_req;
  logic              winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              last_grant_q;
  logic              last_grant_d;

  // Pick the winner: a lone requester always wins, a tie goes to the port not served last
  always_comb begin
    any_req = m0_enable_i | m1_enable_i;
    if (m0_enable_i && m1_enable_i) begin
      winner = ~last_grant_q;
    end else begin
      winner = ~m0_enable_i;
    end
  end
`else
  // Pick the winner: port 0 (dcache) wins whenever it is requesting
  always_comb begin
    any_req = m0_enable_i | m1_enable_i;
    winner  = ~m0_enable_i;
  end
`endif

  // Next-state logic: capture the winner's command in IDLE, freeze it in BUSY until the memory acks
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_o;
    mem_write_d  = mem_write_o;
    mem_addr_d   = mem_addr_o;
    mem_data_d   = mem_data_o;
    owner_d      = owner_o;
    busy_d       = busy_o;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = BUSY;
          mem_enable_d = 1'b1;
          mem_write_d  = winner ? m1_write_i : m0_write_i;
          mem_addr_d   = winner ? m1_addr_i  : m0_addr_i;
          mem_data_d   = winner ? m1_data_i  : m0_data_i;
          owner_d      = winner;
          busy_d       = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d      = IDLE;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
          busy_d       = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = owner_o;
`endif
        end
      end
      default: begin
        state_d      = IDLE;
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and registered memory-port outputs; reset abandons any transfer in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      owner_o      <= 1'b0;
      busy_o       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      mem_enable_o <= mem_enable_d;
      mem_write_o  <= mem_write_d;
      mem_addr_o   <= mem_addr_d;
      mem_data_o   <= mem_data_d;
      owner_o      <= owner_d;
      busy_o       <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Route the memory's ack and read data to the owning port only; an ack outside BUSY is dropped
  always_comb begin
    m0_ack_o  = mem_ack_i & busy_o & ~owner_o;
    m1_ack_o  = mem_ack_i & busy_o &  owner_o;
    m0_data_o = owner_o ? '0 : mem_data_i;
    m1_data_o = owner_o ? mem_data_i : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scoreboard bench: expected transactions are queued in grant
// order, a memory model answers the arbiter, and a monitor pops and
// compares whenever a requester ack appears.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_data_i, m1_data_i;
  logic          m0_ack_o, m1_ack_o;
  logic [DW-1:0] m0_data_o, m1_data_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_data_i;
  logic          owner_o, busy_o;

  typedef struct {
    bit            port;
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t          sb_q[$];
  txn_t          mon_t;
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] store [logic [AW-1:0]];
  bit            spurious = 1'b0;
  int            last_gap = -1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .owner_o(owner_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void pushExpected(input bit p, input bit w, input logic [AW-1:0] a,
                                       input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    txn_t t;
    t.port = p; t.write = w; t.addr = a; t.wdata = wd; t.rdata = rd;
    sb_q.push_back(t);
  endfunction

  // Issue one request on port p and hold it until that port is acked
  task automatic applyStimulus(input bit p, input bit w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input bit keep, input bit scramble);
    bit got = 1'b0;
    bit done_scramble = 1'b0;
    if (!p) begin
      m0_enable_i = 1'b1; m0_write_i = w; m0_addr_i = a; m0_data_i = d;
    end else begin
      m1_enable_i = 1'b1; m1_write_i = w; m1_addr_i = a; m1_data_i = d;
    end
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk_i); #2;
      if (scramble && busy_o && (owner_o == p) && !done_scramble) begin
        done_scramble = 1'b1;
        if (!p) m0_data_i = '0; else m1_data_i = '0;
      end
      if (p ? m1_ack_o : m0_ack_o) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("[TB] FAIL ack_timeout port=%0d addr=%0h actual=no_ack expected=ack", p, a);
    end
    if (!keep) begin
      if (!p) begin m0_enable_i = 1'b0; m0_write_i = 1'b0; end
      else begin m1_enable_i = 1'b0; m1_write_i = 1'b0; end
    end
  endtask

  // Memory model: acks the second cycle the port is enabled, reads/writes a backing store
  initial begin
    int cnt = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      if (spurious) begin
        mem_ack_i  = 1'b1;
        mem_data_i = 256'hFF;
      end else if (mem_enable_o && !rst_i) begin
        cnt++;
        if (cnt == 2) begin
          cnt = 0;
          mem_ack_i = 1'b1;
          if (mem_write_o) store[mem_addr_o] = mem_data_o;
          else mem_data_i = store.exists(mem_addr_o) ? store[mem_addr_o] : 256'hBAD;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every requester ack must match the next expected transaction
  initial begin
    forever begin
      @(negedge clk_i); #2;
      if (m0_ack_o || m1_ack_o) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_ack actual=m0:%0d,m1:%0d expected=none", m0_ack_o, m1_ack_o);
        end else begin
          mon_t = sb_q.pop_front();
          checkOutput("ack_port", m1_ack_o, mon_t.port);
          checkOutput("ack_onehot", m0_ack_o & m1_ack_o, 0);
          checkOutput("owner", owner_o, mon_t.port);
          checkOutput("mem_write", mem_write_o, mon_t.write);
          checkOutput("mem_addr", mem_addr_o, mon_t.addr);
          if (mon_t.write) checkOutput("mem_wdata", mem_data_o, mon_t.wdata);
          checkOutput("owner_rdata", mon_t.port ? m1_data_o : m0_data_o, mon_t.rdata);
          checkOutput("nonowner_data", mon_t.port ? m0_data_o : m1_data_o, 0);
        end
      end
    end
  end

  // Track the number of low samples of mem_enable_o between memory transactions
  initial begin
    int  low_run   = 0;
    bit  seen_high = 1'b0;
    forever begin
      @(negedge clk_i); #2;
      if (mem_enable_o) begin
        if (low_run > 0 && seen_high) last_gap = low_run;
        low_run   = 0;
        seen_high = 1'b1;
      end else begin
        low_run++;
      end
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    rst_i = 1'b1;
    m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
    m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
    store[32'h20]  = 256'h05;
    store[32'h100] = 256'h10;
    store[32'h104] = 256'h11;
    store[32'h108] = 256'h12;
    store[32'h10C] = 256'h13;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_mem_enable", mem_enable_o, 0);
    checkOutput("rst_mem_write", mem_write_o, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_mem_data", mem_data_o, 0);
    checkOutput("rst_owner", owner_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_acks", {m0_ack_o, m1_ack_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset asserted mid-transaction
    @(negedge clk_i);
    m0_enable_i = 1'b1; m0_write_i = 1'b1; m0_addr_i = 32'h40; m0_data_i = 256'h77;
    @(posedge clk_i); #1;
    checkOutput("t1_busy_before_rst", busy_o, 1);
    checkOutput("t1_enable_before_rst", mem_enable_o, 1);
    rst_i = 1'b1;
    #1;
    checkOutput("t1_rst_enable", mem_enable_o, 0);
    checkOutput("t1_rst_write", mem_write_o, 0);
    checkOutput("t1_rst_addr", mem_addr_o, 0);
    checkOutput("t1_rst_data", mem_data_o, 0);
    checkOutput("t1_rst_busy", busy_o, 0);
    checkOutput("t1_rst_owner", owner_o, 0);
    checkOutput("t1_rst_acks", {m0_ack_o, m1_ack_o}, 0);
    m0_enable_i = 1'b0; m0_write_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i); #2;
    checkOutput("t1_idle_after_rst", busy_o, 0);
    checkOutput("t1_enable_after_rst", mem_enable_o, 0);

    // Lone port 0 read with one-cycle grant latency
    @(negedge clk_i);
    pushExpected(1'b0, 1'b0, 32'h20, 256'h0, 256'h05);
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h20; m0_data_i = '0;
    @(posedge clk_i); #1;
    checkOutput("t2_grant_latency", mem_enable_o, 1);
    checkOutput("t2_addr", mem_addr_o, 32'h20);
    checkOutput("t2_write", mem_write_o, 0);
    applyStimulus(1'b0, 1'b0, 32'h20, 256'h0, 1'b0, 1'b0);

    // Port 1 write whose source data changes mid-transfer
    pushExpected(1'b1, 1'b1, 32'h400, 256'hA5, 256'h0);
    applyStimulus(1'b1, 1'b1, 32'h400, 256'hA5, 1'b0, 1'b1);

    // Contention: port 0 keeps four reads going, port 1 wants two
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pushExpected(1'b0, 1'b0, 32'h100, 256'h0, 256'h10);
    pushExpected(1'b1, 1'b0, 32'h400, 256'h0, 256'hA5);
    pushExpected(1'b0, 1'b0, 32'h104, 256'h0, 256'h11);
    pushExpected(1'b1, 1'b0, 32'h20,  256'h0, 256'h05);
    pushExpected(1'b0, 1'b0, 32'h108, 256'h0, 256'h12);
    pushExpected(1'b0, 1'b0, 32'h10C, 256'h0, 256'h13);
`else
    pushExpected(1'b0, 1'b0, 32'h100, 256'h0, 256'h10);
    pushExpected(1'b0, 1'b0, 32'h104, 256'h0, 256'h11);
    pushExpected(1'b0, 1'b0, 32'h108, 256'h0, 256'h12);
    pushExpected(1'b0, 1'b0, 32'h10C, 256'h0, 256'h13);
    pushExpected(1'b1, 1'b0, 32'h400, 256'h0, 256'hA5);
    pushExpected(1'b1, 1'b0, 32'h20,  256'h0, 256'h05);
`endif
    fork
      begin
        applyStimulus(1'b0, 1'b0, 32'h100, 256'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h104, 256'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h108, 256'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h10C, 256'h0, 1'b0, 1'b0);
      end
      begin
        applyStimulus(1'b1, 1'b0, 32'h400, 256'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h20,  256'h0, 1'b0, 1'b0);
      end
    join

    // Spurious memory ack while idle
    repeat (2) @(negedge clk_i);
    #2;
    spurious = 1'b1;
    @(negedge clk_i); #2;
    checkOutput("t5_m0_ack", m0_ack_o, 0);
    checkOutput("t5_m1_ack", m1_ack_o, 0);
    spurious = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("t5_still_idle", busy_o, 0);
    checkOutput("t5_no_enable", mem_enable_o, 0);

    // Back-to-back port 0 requests leave exactly one idle cycle
    @(negedge clk_i);
    last_gap = -1;
    pushExpected(1'b0, 1'b0, 32'h20,  256'h0, 256'h05);
    pushExpected(1'b0, 1'b0, 32'h400, 256'h0, 256'hA5);
    applyStimulus(1'b0, 1'b0, 32'h20,  256'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h400, 256'h0, 1'b0, 1'b0);
    checkOutput("t6_idle_gap", last_gap, 1);

    repeat (4) @(negedge clk_i);
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
